// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Modules derive their own counter width from WIDTH; CNT_W is the default-width value.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  // Bit that goes out first for a word of the given width and bit order.
  function automatic logic head_bit(input logic [31:0] word, input int unsigned width,
                                    input bit msb_first);
    return msb_first ? word[5'(width - 1)] : word[0];
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Mod-WIDTH bit index counter with load and enable; last flags the terminal count.
module ser_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     last
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            last_d, last_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
    last_d = (cnt_d == CntMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = last_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: accepts a word on valid/ready and shifts it out one
// bit per bit_en, with back-to-back words joined seamlessly at the word boundary.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             par_valid,
  output logic             par_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  state_e          state_d, state_q;
  logic [WIDTH-1:0] shift_q;
  logic            ser_out_q;
  logic [CntW-1:0] cnt;
  logic            cnt_at_max;
  logic            accept;
  logic            advance;
  logic            final_bit;

  assign cnt_at_max = (cnt == CntMax);
  assign accept     = par_valid & par_ready;
  assign advance    = (state_q == SHIFT) & bit_en;
  assign final_bit  = advance & cnt_at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (final_bit) state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    par_ready = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:  par_ready = !rst;
      SHIFT: begin
        par_ready = !rst & cnt_at_max & bit_en;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // shift_q always holds the bits not yet on ser_out, next bit at the head position.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      ser_out_q <= IDLE_BIT;
    end else if (accept) begin
      shift_q   <= MSB_FIRST ? (par_in << 1) : (par_in >> 1);
      ser_out_q <= head_bit(32'(par_in), WIDTH, MSB_FIRST);
    end else if (final_bit) begin
      ser_out_q <= IDLE_BIT;
    end else if (advance) begin
      shift_q   <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
      ser_out_q <= head_bit(32'(shift_q), WIDTH, MSB_FIRST);
    end
  end

  ser_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .en  (advance & ~accept),
    .cnt (cnt),
    .last(last)
  );

  assign ser_out   = ser_out_q;
  assign ser_valid = busy;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance share clock,
// reset and bit_en; each step checks outputs 1 ns after the rising edge.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic [7:0] par_in, par_in2;
  logic       par_valid, par_valid2;
  logic       par_ready, par_ready2;
  logic       ser_out, ser_out2;
  logic       ser_valid, ser_valid2;
  logic       last, last2;
  logic       busy, busy2;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .par_in   (par_in),
    .par_valid(par_valid),
    .par_ready(par_ready),
    .bit_en   (bit_en),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .last     (last),
    .busy     (busy)
  );

  piso_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b0),
    .IDLE_BIT (1'b0)
  ) dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .par_in   (par_in2),
    .par_valid(par_valid2),
    .par_ready(par_ready2),
    .bit_en   (bit_en),
    .ser_out  (ser_out2),
    .ser_valid(ser_valid2),
    .last     (last2),
    .busy     (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  w;
    logic [7:0]  w2;
    logic [15:0] stream;
    logic [7:0]  junk [7];

    rst        = 1'b1;
    bit_en     = 1'b1;
    par_in     = 8'h00;
    par_valid  = 1'b0;
    par_in2    = 8'h00;
    par_valid2 = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst ser_valid", 32'(ser_valid), 0);
    chk("rst ser_out", 32'(ser_out), 0);
    chk("rst last", 32'(last), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst par_ready", 32'(par_ready), 0);
    chk("rst lsb ser_valid", 32'(ser_valid2), 0);
    rst = 1'b0;
    #1;
    chk("idle par_ready", 32'(par_ready), 1);

    // Single word 0xB4 MSB-first, and 0x01 LSB-first on the second instance
    w          = 8'hB4;
    w2         = 8'h01;
    par_in     = w;
    par_valid  = 1'b1;
    par_in2    = w2;
    par_valid2 = 1'b1;
    tick();
    par_valid  = 1'b0;
    par_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single bit %0d", i), 32'(ser_out), 32'(w[7-i]));
      chk($sformatf("single valid %0d", i), 32'(ser_valid), 1);
      chk($sformatf("single last %0d", i), 32'(last), 32'(i == 7));
      chk($sformatf("lsb bit %0d", i), 32'(ser_out2), 32'(w2[i]));
      chk($sformatf("lsb last %0d", i), 32'(last2), 32'(i == 7));
      tick();
    end
    chk("single end valid", 32'(ser_valid), 0);
    chk("single end ser_out", 32'(ser_out), 0);
    chk("single end busy", 32'(busy), 0);
    chk("lsb end valid", 32'(ser_valid2), 0);

    // Back-to-back 0xB4 then 0x5A
    stream    = 16'hB45A;
    par_in    = 8'hB4;
    par_valid = 1'b1;
    tick();
    par_in = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b bit %0d", i), 32'(ser_out), 32'(stream[15-i]));
      chk($sformatf("b2b valid %0d", i), 32'(ser_valid), 1);
      if (i == 0) chk("b2b ready mid-word", 32'(par_ready), 0);
      if (i == 7) begin
        chk("b2b last at boundary", 32'(last), 1);
        chk("b2b ready at boundary", 32'(par_ready), 1);
      end
      tick();
      if (i == 7) par_valid = 1'b0;
    end
    chk("b2b end valid", 32'(ser_valid), 0);

    // bit_en throttled to one cycle in three, word 0xF0
    w         = 8'hF0;
    bit_en    = 1'b0;
    par_in    = w;
    par_valid = 1'b1;
    tick();
    par_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < 3; p++) begin
        bit_en = (p == 2);
        #1;
        chk($sformatf("thr bit %0d.%0d", b, p), 32'(ser_out), 32'(w[7-b]));
        chk($sformatf("thr valid %0d.%0d", b, p), 32'(ser_valid), 1);
        chk($sformatf("thr ready %0d.%0d", b, p), 32'(par_ready), 32'(b == 7 && p == 2));
        tick();
      end
    end
    chk("thr end valid", 32'(ser_valid), 0);
    bit_en = 1'b1;

    // Reset at the 4th bit of 0xFF, with 0x81 offered during reset
    par_in    = 8'hFF;
    par_valid = 1'b1;
    tick();
    par_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid 4th bit", 32'(ser_out), 1);
    chk("mid busy", 32'(busy), 1);
    rst       = 1'b1;
    par_in    = 8'h81;
    par_valid = 1'b1;
    #1;
    chk("mid ready in rst", 32'(par_ready), 0);
    tick();
    chk("mid rst valid", 32'(ser_valid), 0);
    chk("mid rst ser_out", 32'(ser_out), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst last", 32'(last), 0);
    rst = 1'b0;
    #1;
    chk("post rst ready", 32'(par_ready), 1);
    w = 8'h81;
    tick();
    par_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post rst bit %0d", i), 32'(ser_out), 32'(w[7-i]));
      chk($sformatf("post rst valid %0d", i), 32'(ser_valid), 1);
      tick();
    end
    chk("post rst end valid", 32'(ser_valid), 0);

    // Hold-off: par_in changes while busy; only the value at par_ready=1 is taken
    junk      = '{8'h3C, 8'hFF, 8'h00, 8'hAA, 8'h55, 8'h0F, 8'hE1};
    stream    = 16'hC396;
    par_in    = 8'hC3;
    par_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i < 7) par_in = junk[i];
      else if (i == 7) par_in = 8'h96;
      #1;
      chk($sformatf("hold bit %0d", i), 32'(ser_out), 32'(stream[15-i]));
      chk($sformatf("hold valid %0d", i), 32'(ser_valid), 1);
      tick();
      if (i == 7) par_valid = 1'b0;
    end
    chk("hold end valid", 32'(ser_valid), 0);
    chk("hold end ser_out", 32'(ser_out), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
